// File: rtl/pdm_pkg.sv
// Shared types and helpers for the multi-channel PDM block.
// Output-stage state encoding and the accumulator full-scale value.
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_HI,
    ST_LO,
    ST_DEAD
  } st_t;

  function automatic logic [31:0] max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pdm_chan.sv
// One PDM channel: duty register, first-order accumulator and
// a complementary output stage with dead-time insertion.
module pdm_chan
  import pdm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEAD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_wr,
  output logic             pdm,
  output logic             pdm_n,
  output logic             busy
);

  localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [31:0] MAX32 = max_of(WIDTH);
  localparam logic [WIDTH-1:0] MAX = MAX32[WIDTH-1:0];
  localparam logic [DW-1:0] DLOAD = DW'(DEAD);
  localparam logic [DW-1:0] DONE = DW'(1);

  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             raw;
  logic             sw;
  st_t              st;
  st_t              st_nxt;
  logic [DW-1:0]    dcnt;
  logic [DW-1:0]    dcnt_nxt;

  assign raw     = (duty_act >= acc);
  assign acc_nxt = acc + (raw ? MAX : '0) - duty_act;

  // Active duty register, loaded by the strobe independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act <= '0;
    end else if (duty_wr) begin
      duty_act <= duty_in;
    end
  end

  // Accumulator, cleared and held while modulation is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (!en) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

  // Does the driven side disagree with the modulator bit?
  always_comb begin
    sw = 1'b0;
    unique case (st)
      ST_OFF:  sw = 1'b1;
      ST_HI:   sw = !raw;
      ST_LO:   sw = raw;
      default: sw = 1'b0;
    endcase
  end

  // Next output-stage state; dead-time is skipped when DEAD is 0.
  always_comb begin
    st_nxt   = st;
    dcnt_nxt = dcnt;
    if (!en) begin
      st_nxt   = ST_OFF;
      dcnt_nxt = '0;
    end else if (st == ST_DEAD) begin
      if (dcnt == '0) begin
        st_nxt = raw ? ST_HI : ST_LO;
      end else begin
        dcnt_nxt = dcnt - DONE;
      end
    end else if (sw) begin
      if (DEAD == 0) begin
        st_nxt = raw ? ST_HI : ST_LO;
      end else begin
        st_nxt   = ST_DEAD;
        dcnt_nxt = DLOAD;
      end
    end
  end

  // State and outputs registered together so pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= ST_OFF;
      dcnt  <= '0;
      pdm   <= 1'b0;
      pdm_n <= 1'b0;
      busy  <= 1'b0;
    end else begin
      st    <= st_nxt;
      dcnt  <= dcnt_nxt;
      pdm   <= (st_nxt == ST_HI);
      pdm_n <= (st_nxt == ST_LO);
      busy  <= (st_nxt == ST_DEAD);
    end
  end

endmodule

// File: rtl/pdm_multi.sv
// Multi-channel PDM: CH independent channels sharing clock,
// reset and enable, each with its own duty slice and strobe.
module pdm_multi
  import pdm_pkg::*;
#(
  parameter int CH    = 4,
  parameter int WIDTH = 16,
  parameter int DEAD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CH*WIDTH-1:0] duty_in,
  input  logic [CH-1:0]       duty_wr,
  output logic [CH-1:0]       pdm,
  output logic [CH-1:0]       pdm_n,
  output logic [CH-1:0]       busy
);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    pdm_chan #(
      .WIDTH(WIDTH),
      .DEAD (DEAD)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .duty_in(duty_in[k*WIDTH +: WIDTH]),
      .duty_wr(duty_wr[k]),
      .pdm    (pdm[k]),
      .pdm_n  (pdm_n[k]),
      .busy   (busy[k])
    );
  end

endmodule

// File: tb/tb_pdm_multi.sv
// Directed bench for pdm_multi: one DEAD=0 and one DEAD=3
// instance (CH=4, WIDTH=4) driven side by side.
module tb_pdm_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] d0_in;
  logic [3:0]  d0_wr;
  logic [3:0]  p0, n0, b0;
  logic [15:0] d1_in;
  logic [3:0]  d1_wr;
  logic [3:0]  p1, n1, b1;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [3:0] m_acc [4];
  logic [3:0] m_duty[4];
  logic [3:0] mraw;
  int         run   [4];

  int v_both = 0;
  int v_comp0 = 0;
  int v_busy1 = 0;
  int v_run = 0;
  int v_side = 0;
  int runs_seen = 0;
  int hi_sides = 0;

  logic [149:0] s1;
  logic [59:0]  s2;
  logic [59:0]  c2;
  logic [2:0]   lead1;
  logic [2:0]   rest1_p;
  logic [2:0]   rest1_n;
  logic         c1_all;
  logic         c1_nany;
  logic         c3_lead;
  logic         c3_rest;
  int           ones;

  pdm_multi #(.CH(4), .WIDTH(4), .DEAD(0)) u0 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .duty_in(d0_in),
    .duty_wr(d0_wr),
    .pdm    (p0),
    .pdm_n  (n0),
    .busy   (b0)
  );

  pdm_multi #(.CH(4), .WIDTH(4), .DEAD(3)) u1 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .duty_in(d1_in),
    .duty_wr(d1_wr),
    .pdm    (p1),
    .pdm_n  (n1),
    .busy   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_acc[k]  = 4'd0;
      m_duty[k] = 4'd0;
      run[k]    = 0;
    end
  endtask

  task automatic tick();
    logic       en_q;
    logic [3:0] wr_q;
    logic [15:0] din_q;
    en_q  = en;
    wr_q  = d1_wr;
    din_q = d1_in;
    for (int k = 0; k < 4; k++) mraw[k] = (m_duty[k] >= m_acc[k]);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = en_q ? (m_acc[k] + (mraw[k] ? 4'd15 : 4'd0) - m_duty[k])
                      : 4'd0;
      if (wr_q[k]) m_duty[k] = din_q[k*4 +: 4];
    end
    if (((p0 & n0) | (p1 & n1)) != 4'd0) v_both++;
    if (b0 != 4'd0) v_comp0++;
    if (en_q && (n0 != ~p0)) v_comp0++;
    if (!en_q && ((p0 | n0) != 4'd0)) v_comp0++;
    if (b1 != ({4{en_q}} & ~p1 & ~n1)) v_busy1++;
    for (int k = 0; k < 4; k++) begin
      if (!en_q) begin
        run[k] = 0;
      end else if (!p1[k] && !n1[k]) begin
        run[k]++;
      end else if (run[k] > 0) begin
        runs_seen++;
        if (run[k] != 4) v_run++;
        if (p1[k] != mraw[k]) v_side++;
        if (p1[k]) hi_sides++;
        run[k] = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    d0_in = '0;
    d0_wr = '0;
    d1_in = '0;
    d1_wr = '0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_u0_out", {p0, n0, b0}, 0);
    chk("rst_u1_out", {p1, n1, b1}, 0);
    rst = 1'b0;

    tick();
    chk("idle_en0", {p0, n0, p1, n1, b1}, 0);

    d0_in = {4'd0, 4'd0, 4'd0, 4'd8};
    d0_wr = 4'b0001;
    d1_in = {4'd0, 4'd15, 4'd10, 4'd5};
    d1_wr = 4'b1111;
    tick();
    d0_wr = '0;
    d1_wr = '0;
    chk("load_no_en", {p0, n0, p1, n1}, 0);

    en = 1'b1;
    ones = 0;
    lead1 = '0;
    rest1_p = '0;
    rest1_n = 3'b111;
    for (int i = 0; i < 150; i++) begin
      tick();
      s1[i] = p0[0];
      ones += int'(p0[0]);
      if (i == 0) begin
        lead1 = p0[3:1];
      end else begin
        rest1_p = rest1_p | p0[3:1];
        rest1_n = rest1_n & n0[3:1];
      end
    end
    chk("ch0_first16", s1[15:0], 16'b0110101010101011);
    chk("ch0_density", (ones >= 79 && ones <= 81), 1);
    chk("ch123_lead", lead1, 3'b111);
    chk("ch123_pdm0", rest1_p, 3'b000);
    chk("ch123_pdmn1", rest1_n, 3'b111);

    en = 1'b0;
    tick();
    chk("en_off_u0", {p0, n0}, 0);
    chk("en_off_u1", {p1, n1, b1}, 0);

    d0_in = {4'd0, 4'd0, 4'd15, 4'd8};
    d0_wr = 4'b1111;
    tick();
    d0_wr = '0;

    en = 1'b1;
    c1_all = 1'b1;
    c1_nany = 1'b0;
    c3_lead = 1'b0;
    c3_rest = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) begin
        d0_in[11:8] = 4'd8;
        d0_wr = 4'b0100;
      end
      tick();
      d0_wr = '0;
      s2[i] = p0[0];
      c2[i] = p0[2];
      c1_all = c1_all & p0[1];
      c1_nany = c1_nany | n0[1];
      if (i == 0) c3_lead = p0[3];
      else c3_rest = c3_rest | p0[3];
    end
    chk("restart_ch0", s2, s1[59:0]);
    chk("duty15_hi", c1_all, 1);
    chk("duty15_n_lo", c1_nany, 0);
    chk("ch3_lead", c3_lead, 1);
    chk("ch3_rest", c3_rest, 0);
    chk("ch2_lead", c2[0], 1);
    chk("ch2_before", c2[51:1], 0);
    chk("ch2_after", c2[56:52], 5'b10101);

    chk("pre_rst_hi", p0[1], 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_u0", {p0, n0}, 0);
    chk("async_rst_u1", {p1, n1, b1}, 0);
    #1;
    rst = 1'b0;
    model_clear();

    tick();
    chk("post_rst_lead", p0, 4'b1111);
    tick();
    chk("post_rst_pdm", p0, 4'b0000);
    chk("post_rst_pdmn", n0, 4'b1111);
    repeat (4) tick();
    chk("post_rst_u1_lo", {p1, n1}, 8'b0000_1111);

    chk("never_both", v_both, 0);
    chk("u0_compl", v_comp0, 0);
    chk("u1_busy", v_busy1, 0);
    chk("u1_dead_len", v_run, 0);
    chk("u1_side", v_side, 0);
    chk("u1_runs", runs_seen > 10, 1);
    chk("u1_hi_seen", hi_sides > 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
